// File: rtl/cd_host_if_if.sv
// A-bus CS2 signal bundle between the SCU port (master) and the CD host
// register block (slave).
interface cd_host_if_if;
  logic [25:0] AA;
  logic [15:0] ADO;
  logic [15:0] ADI;
  logic        ACS2_N;
  logic        ARD_N;
  logic        AWRL_N;
  logic        AWRU_N;
  logic        AIRQ_N;

  modport master (
    output AA, ADO, ACS2_N, ARD_N, AWRL_N, AWRU_N,
    input  ADI, AIRQ_N
  );

  modport slave (
    input  AA, ADO, ACS2_N, ARD_N, AWRL_N, AWRU_N,
    output ADI, AIRQ_N
  );
endinterface

// File: rtl/cd_host_if.sv
// CD-block host registers (HIRQ, HIRQMASK, CR1-CR4), command handshake to the
// CD core and the sector data FIFO drained by the host through DTR.
module cd_host_if #(
  parameter int FIFO_AW = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE_R,
  cd_host_if_if.slave        abus,
  output logic               CMD_REQ,
  output logic [63:0]        CMD_CR,
  input  logic               CMD_ACK,
  input  logic               RESP_VALID,
  input  logic [63:0]        RESP_CR,
  input  logic [15:0]        HIRQ_SET,
  input  logic               DATA_WR,
  input  logic [15:0]        DATA_D,
  output logic               DATA_FULL,
  output logic [FIFO_AW:0]   FIFO_CNT
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [63:0] CR_RST = 64'h0043_4442_4C4F_434B;

  function automatic logic [15:0] lane_merge(input logic [15:0] old,
                                             input logic [15:0] din,
                                             input logic        wu,
                                             input logic        wl);
    return {wu ? din[15:8] : old[15:8], wl ? din[7:0] : old[7:0]};
  endfunction

  logic               hit, wr, rd, wu, wl, wr_ev, push_ok, pop_ok, unused_aa0;
  logic [15:0]        ofs, adi, hirq_clr;
  logic [15:0]        hirq_q, hirq_d, mask_q, mask_d;
  logic [63:0]        cr_q, cr_d, cmd_cr_q, cmd_cr_d;
  logic               cmd_req_q, cmd_req_d, airq_n_q, airq_n_d;
  logic               wr_hist_q, dtr_rd_q;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [15:0]        mem_q [DEPTH];

  assign hit        = !abus.ACS2_N && (abus.AA[25:16] == 10'h189);
  assign ofs        = {abus.AA[15:1], 1'b0};
  assign unused_aa0 = abus.AA[0];
  assign wu         = !abus.AWRU_N;
  assign wl         = !abus.AWRL_N;
  assign wr         = hit && (wu || wl);
  assign rd         = hit && !abus.ARD_N;

  // Host strobes span many cycles: act on the leading edge of a write and
  // the trailing edge of a DTR read.
  assign wr_ev   = CE_R && wr && !wr_hist_q;
  assign pop_ok  = CE_R && dtr_rd_q && !rd && (cnt_q != '0);
  assign push_ok = CE_R && DATA_WR && (!DATA_FULL || pop_ok);

  always_comb begin
    hirq_clr  = 16'hFFFF;
    mask_d    = mask_q;
    cr_d      = cr_q;
    cmd_cr_d  = cmd_cr_q;
    cmd_req_d = cmd_req_q;
    if (CMD_ACK) cmd_req_d = 1'b0;
    if (wr_ev) begin
      case (ofs)
        16'h0008: hirq_clr     = lane_merge(16'hFFFF, abus.ADO, wu, wl);
        16'h000C: mask_d       = lane_merge(mask_q, abus.ADO, wu, wl);
        16'h0018: cr_d[63:48]  = lane_merge(cr_q[63:48], abus.ADO, wu, wl);
        16'h001C: cr_d[47:32]  = lane_merge(cr_q[47:32], abus.ADO, wu, wl);
        16'h0020: cr_d[31:16]  = lane_merge(cr_q[31:16], abus.ADO, wu, wl);
        16'h0024: begin
          cr_d[15:0] = lane_merge(cr_q[15:0], abus.ADO, wu, wl);
          cmd_cr_d   = {cr_q[63:16], cr_d[15:0]};
          cmd_req_d  = 1'b1;
        end
        default: ;
      endcase
    end
    // A core response overrides any host CR write in the same cycle.
    if (RESP_VALID) cr_d = RESP_CR;
    hirq_d   = (hirq_q & hirq_clr) | HIRQ_SET | {15'd0, RESP_VALID};
    airq_n_d = ~|(hirq_d & mask_d);
  end

  always_comb begin
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hirq_q    <= 16'hFFFF;
      mask_q    <= 16'hFFFF;
      cr_q      <= CR_RST;
      cmd_req_q <= 1'b0;
      cmd_cr_q  <= '0;
      airq_n_q  <= 1'b1;
      wr_hist_q <= 1'b0;
      dtr_rd_q  <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else if (CE_R) begin
      hirq_q    <= hirq_d;
      mask_q    <= mask_d;
      cr_q      <= cr_d;
      cmd_req_q <= cmd_req_d;
      cmd_cr_q  <= cmd_cr_d;
      airq_n_q  <= airq_n_d;
      wr_hist_q <= wr;
      dtr_rd_q  <= rd && (ofs == 16'h0000);
      cnt_q     <= cnt_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wptr_q] <= DATA_D;
  end

  always_comb begin
    adi = 16'hFFFF;
    if (hit) begin
      case (ofs)
        16'h0000: adi = (cnt_q == '0) ? 16'h0000 : mem_q[rptr_q];
        16'h0008: adi = hirq_q;
        16'h000C: adi = mask_q;
        16'h0018: adi = cr_q[63:48];
        16'h001C: adi = cr_q[47:32];
        16'h0020: adi = cr_q[31:16];
        16'h0024: adi = cr_q[15:0];
        default:  adi = 16'hFFFF;
      endcase
    end
  end

  assign abus.ADI    = adi;
  assign abus.AIRQ_N = airq_n_q;
  assign CMD_REQ     = cmd_req_q;
  assign CMD_CR      = cmd_cr_q;
  assign FIFO_CNT    = cnt_q;
  assign DATA_FULL   = cnt_q[FIFO_AW];

endmodule

// File: tb/tb_cd_host_if.sv
// Directed bench for cd_host_if: transaction-level register/FIFO model checked
// every cycle, plus literal expectations along the test sequence.
module tb_cd_host_if;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST, CE_R;
  logic          CMD_REQ, CMD_ACK, RESP_VALID, DATA_WR, DATA_FULL;
  logic [63:0]   CMD_CR, RESP_CR;
  logic [15:0]   HIRQ_SET, DATA_D;
  logic [AW:0]   FIFO_CNT;

  cd_host_if_if bus();

  cd_host_if #(.FIFO_AW(AW)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .abus(bus),
    .CMD_REQ(CMD_REQ), .CMD_CR(CMD_CR), .CMD_ACK(CMD_ACK),
    .RESP_VALID(RESP_VALID), .RESP_CR(RESP_CR), .HIRQ_SET(HIRQ_SET),
    .DATA_WR(DATA_WR), .DATA_D(DATA_D), .DATA_FULL(DATA_FULL),
    .FIFO_CNT(FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state; host events are announced by the stimulus tasks.
  logic [15:0] m_hirq, m_mask;
  logic [63:0] m_cr, m_cmd;
  logic        m_req, m_airq_n;
  logic [15:0] m_fifo[$];
  logic        ev_wr = 1'b0, ev_pop = 1'b0;
  logic [15:0] ev_ofs = '0, ev_data = '0;
  logic [1:0]  ev_be = '0;

  function automatic logic [15:0] bytes(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[1]) r[15:8] = d[15:8];
    if (be[0]) r[7:0]  = d[7:0];
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    logic [15:0] clr;
    if (RST) begin
      m_hirq = 16'hFFFF; m_mask = 16'hFFFF; m_cr = 64'h0043_4442_4C4F_434B;
      m_cmd = '0; m_req = 1'b0; m_airq_n = 1'b1; m_fifo.delete();
    end else if (CE_R) begin
      clr = 16'hFFFF;
      if (CMD_ACK) m_req = 1'b0;
      if (ev_wr) begin
        case (ev_ofs)
          16'h0008: clr = bytes(16'hFFFF, ev_data, ev_be);
          16'h000C: m_mask = bytes(m_mask, ev_data, ev_be);
          16'h0018: m_cr[63:48] = bytes(m_cr[63:48], ev_data, ev_be);
          16'h001C: m_cr[47:32] = bytes(m_cr[47:32], ev_data, ev_be);
          16'h0020: m_cr[31:16] = bytes(m_cr[31:16], ev_data, ev_be);
          16'h0024: begin
            m_cr[15:0] = bytes(m_cr[15:0], ev_data, ev_be);
            m_cmd = m_cr; m_req = 1'b1;
          end
          default: ;
        endcase
      end
      if (RESP_VALID) m_cr = RESP_CR;
      m_hirq = (m_hirq & clr) | HIRQ_SET | (RESP_VALID ? 16'h0001 : 16'h0000);
      m_airq_n = ((m_hirq & m_mask) == 16'h0000);
      if (ev_pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (DATA_WR && m_fifo.size() < (1 << AW)) m_fifo.push_back(DATA_D);
    end
  end

  function automatic logic [15:0] m_adi();
    if (bus.ACS2_N || bus.AA[25:16] != 10'h189) return 16'hFFFF;
    case ({bus.AA[15:1], 1'b0})
      16'h0000: return (m_fifo.size() > 0) ? m_fifo[0] : 16'h0000;
      16'h0008: return m_hirq;
      16'h000C: return m_mask;
      16'h0018: return m_cr[63:48];
      16'h001C: return m_cr[47:32];
      16'h0020: return m_cr[31:16];
      16'h0024: return m_cr[15:0];
      default:  return 16'hFFFF;
    endcase
  endfunction

  always @(posedge CLK) begin
    #2;
    if (cmp_en && !RST) begin
      chk("ADI", bus.ADI, m_adi());
      chk("AIRQ_N", bus.AIRQ_N, m_airq_n);
      chk("CMD_REQ", CMD_REQ, m_req);
      chk("CMD_CR", CMD_CR, m_cmd);
      chk("FIFO_CNT", FIFO_CNT, m_fifo.size());
      chk("DATA_FULL", DATA_FULL, m_fifo.size() == (1 << AW));
    end
  end

  task automatic bus_idle();
    bus.ACS2_N = 1'b1; bus.ARD_N = 1'b1; bus.AWRL_N = 1'b1; bus.AWRU_N = 1'b1;
  endtask

  task automatic host_wr(input logic [15:0] ofs, input logic [15:0] d, input logic [1:0] be,
                         input int hold, input int ack_cyc, input logic [15:0] hset,
                         input logic rv);
    @(negedge CLK);
    bus.AA = {10'h189, ofs}; bus.ADO = d; bus.ACS2_N = 1'b0;
    bus.AWRU_N = !be[1]; bus.AWRL_N = !be[0];
    for (int i = 0; i < hold; i++) begin
      ev_wr = (i == 0); ev_ofs = ofs; ev_data = d; ev_be = be;
      CMD_ACK = (i == ack_cyc);
      HIRQ_SET = (i == 0) ? hset : 16'h0000;
      RESP_VALID = (i == 0) && rv;
      @(negedge CLK);
    end
    ev_wr = 1'b0; CMD_ACK = 1'b0; HIRQ_SET = '0; RESP_VALID = 1'b0;
    bus_idle();
  endtask

  task automatic wr1(input logic [15:0] ofs, input logic [15:0] d);
    host_wr(ofs, d, 2'b11, 1, -1, 16'h0000, 1'b0);
  endtask

  task automatic host_rd(input string nm, input logic [15:0] ofs, input int hold,
                         input logic [15:0] exp, input logic push, input logic [15:0] pd);
    @(negedge CLK);
    bus.AA = {10'h189, ofs}; bus.ACS2_N = 1'b0; bus.ARD_N = 1'b0;
    @(posedge CLK); #2;
    chk(nm, bus.ADI, exp);
    for (int i = 0; i < hold; i++) @(negedge CLK);
    bus_idle();
    ev_pop = (ofs == 16'h0000);
    if (push) begin DATA_WR = 1'b1; DATA_D = pd; end
    @(negedge CLK);
    ev_pop = 1'b0; DATA_WR = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge CLK); DATA_WR = 1'b1; DATA_D = d;
    @(negedge CLK); DATA_WR = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge CLK); CMD_ACK = 1'b1;
    @(negedge CLK); CMD_ACK = 1'b0;
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b1; CMD_ACK = 1'b0; RESP_VALID = 1'b0; RESP_CR = '0;
    HIRQ_SET = '0; DATA_WR = 1'b0; DATA_D = '0; bus.AA = '0; bus.ADO = '0;
    bus_idle();
    #1;
    chk("rst AIRQ_N", bus.AIRQ_N, 1'b1);
    chk("rst CMD_REQ", CMD_REQ, 1'b0);
    chk("rst FIFO_CNT", FIFO_CNT, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0; cmp_en = 1'b1;

    host_rd("rst CR1", 16'h0018, 1, 16'h0043, 1'b0, 16'h0);
    host_rd("rst CR2", 16'h001C, 1, 16'h4442, 1'b0, 16'h0);
    host_rd("rst CR3", 16'h0020, 1, 16'h4C4F, 1'b0, 16'h0);
    host_rd("rst CR4", 16'h0024, 1, 16'h434B, 1'b0, 16'h0);
    host_rd("rst HIRQ", 16'h0008, 1, 16'hFFFF, 1'b0, 16'h0);
    host_rd("unmapped", 16'h0010, 1, 16'hFFFF, 1'b0, 16'h0);

    // Interrupt path.
    wr1(16'h000C, 16'h0001);
    wr1(16'h0008, 16'h0000);
    @(posedge CLK); #2 chk("AIRQ masked clear", bus.AIRQ_N, 1'b1);
    @(negedge CLK); HIRQ_SET = 16'h0001;
    @(negedge CLK); HIRQ_SET = 16'h0000;
    chk("AIRQ after set", bus.AIRQ_N, 1'b0);
    host_wr(16'h0008, 16'h0000, 2'b11, 1, -1, 16'h0001, 1'b0);
    host_rd("HIRQ set wins", 16'h0008, 1, 16'h0001, 1'b0, 16'h0);
    wr1(16'h0008, 16'hFFFE);

    // Command handshake.
    wr1(16'h0018, 16'h1234);
    wr1(16'h001C, 16'h5678);
    wr1(16'h0020, 16'h9ABC);
    host_wr(16'h0024, 16'hDEF0, 2'b11, 5, -1, 16'h0000, 1'b0);
    chk("CMD_REQ set", CMD_REQ, 1'b1);
    chk("CMD_CR latch", CMD_CR, 64'h1234_5678_9ABC_DEF0);
    pulse_ack();
    chk("CMD_REQ ack", CMD_REQ, 1'b0);
    host_wr(16'h0024, 16'hDEF1, 2'b11, 5, 2, 16'h0000, 1'b0);
    chk("held CR4 single event", CMD_REQ, 1'b0);
    chk("held CR4 latch", CMD_CR, 64'h1234_5678_9ABC_DEF1);
    wr1(16'h0024, 16'h1111);
    wr1(16'h0024, 16'h2222);
    chk("relatch REQ", CMD_REQ, 1'b1);
    chk("relatch CR", CMD_CR, 64'h1234_5678_9ABC_2222);
    pulse_ack();
    pulse_ack();

    // Response.
    @(negedge CLK); RESP_CR = 64'h0102_0304_0506_0708; RESP_VALID = 1'b1;
    @(negedge CLK); RESP_VALID = 1'b0;
    host_rd("resp CR1", 16'h0018, 1, 16'h0102, 1'b0, 16'h0);
    host_rd("resp CR2", 16'h001C, 1, 16'h0304, 1'b0, 16'h0);
    host_rd("resp CR3", 16'h0020, 1, 16'h0506, 1'b0, 16'h0);
    host_rd("resp CR4", 16'h0024, 1, 16'h0708, 1'b0, 16'h0);
    host_rd("resp HIRQ", 16'h0008, 1, 16'h0001, 1'b0, 16'h0);
    RESP_CR = 64'h1111_2222_3333_4444;
    host_wr(16'h001C, 16'hBEEF, 2'b11, 1, -1, 16'h0000, 1'b1);
    host_rd("resp beats write", 16'h001C, 1, 16'h2222, 1'b0, 16'h0);
    host_wr(16'h0020, 16'hAB77, 2'b01, 1, -1, 16'h0000, 1'b0);
    host_rd("low lane", 16'h0020, 1, 16'h3377, 1'b0, 16'h0);
    host_wr(16'h0018, 16'h55AA, 2'b10, 1, -1, 16'h0000, 1'b0);
    host_rd("high lane", 16'h0018, 1, 16'h5511, 1'b0, 16'h0);

    // FIFO drain through DTR.
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
    chk("FIFO 3", FIFO_CNT, 3);
    host_rd("DTR 1", 16'h0000, 4, 16'hAAAA, 1'b0, 16'h0);
    host_rd("DTR 2", 16'h0000, 4, 16'hBBBB, 1'b0, 16'h0);
    host_rd("DTR 3", 16'h0000, 4, 16'hCCCC, 1'b0, 16'h0);
    host_rd("DTR empty", 16'h0000, 4, 16'h0000, 1'b0, 16'h0);
    chk("FIFO drained", FIFO_CNT, 0);

    // Full, drop, simultaneous push/pop across the pointer wrap.
    for (int i = 1; i <= 5; i++) push(16'(i));
    chk("full cnt", FIFO_CNT, 4);
    chk("full flag", DATA_FULL, 1'b1);
    host_rd("full head", 16'h0000, 1, 16'h0001, 1'b1, 16'h0006);
    chk("push+pop cnt", FIFO_CNT, 4);
    host_rd("wrap 2", 16'h0000, 1, 16'h0002, 1'b0, 16'h0);
    host_rd("wrap 3", 16'h0000, 1, 16'h0003, 1'b0, 16'h0);
    host_rd("wrap 4", 16'h0000, 1, 16'h0004, 1'b0, 16'h0);
    host_rd("wrap 6", 16'h0000, 1, 16'h0006, 1'b0, 16'h0);
    chk("wrap drained", FIFO_CNT, 0);

    // Clock enable low blocks every update.
    @(negedge CLK); CE_R = 1'b0; DATA_WR = 1'b1; DATA_D = 16'h7777; HIRQ_SET = 16'h0100;
    repeat (2) @(negedge CLK);
    DATA_WR = 1'b0; HIRQ_SET = '0; CE_R = 1'b1;
    chk("CE_R low no push", FIFO_CNT, 0);
    host_rd("CE_R low HIRQ", 16'h0008, 1, 16'h0001, 1'b0, 16'h0);

    // Asynchronous reset mid-command and mid-transfer.
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
    wr1(16'h0024, 16'h5555);
    chk("pre-rst REQ", CMD_REQ, 1'b1);
    chk("pre-rst cnt", FIFO_CNT, 3);
    @(posedge CLK); #3;
    cmp_en = 1'b0; RST = 1'b1;
    bus.AA = {10'h189, 16'h0018}; bus.ACS2_N = 1'b0; bus.ARD_N = 1'b0;
    #1;
    chk("async CMD_REQ", CMD_REQ, 1'b0);
    chk("async CMD_CR", CMD_CR, 64'h0);
    chk("async FIFO_CNT", FIFO_CNT, 0);
    chk("async DATA_FULL", DATA_FULL, 1'b0);
    chk("async AIRQ_N", bus.AIRQ_N, 1'b1);
    chk("async CR1", bus.ADI, 16'h0043);
    bus.AA = {10'h189, 16'h0008};
    #1 chk("async HIRQ", bus.ADI, 16'hFFFF);
    bus_idle();
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
